// File: rtl/param_sync_dp_ram.sv
// Simple-dual-port synchronous RAM: one write port with byte enables, one read port.
// Optional output register, read-during-write mode select and a post-reset clear sequencer.
module param_sync_dp_ram #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NBYTES-1:0]       wr_be;

    logic                    rd_en;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_merged;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;

    // Write port is shared between the clear sequencer and the user port.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        wr_en       = 1'b0;
        wr_addr     = waddr;
        wr_data     = din;
        wr_be       = be;
        rd_en       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clear_ptr_q;
                wr_data     = '0;
                wr_be       = '1;
                clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
                if (clear_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                wr_en = we;
                rd_en = re;
            end
        endcase
        if (rst) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    always_comb begin
        rd_word   = mem[raddr];
        collide   = wr_en && (state_q == ST_IDLE) && (waddr == raddr);
        rd_merged = rd_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (collide && be[i]) begin
                rd_merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    always_comb begin
        s1_valid_d = rd_en;
        s1_data_d  = s1_data_q;
        if (rd_en) begin
            s1_data_d = (RD_MODE != 0) ? rd_merged : rd_word;
        end
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clear_ptr_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
        end
    end

    assign dout       = (OUT_REG != 0) ? s2_data_q : s1_data_q;
    assign dout_valid = (OUT_REG != 0) ? s2_valid_q : s1_valid_q;
    assign busy       = (state_q == ST_CLEAR) || (rst && (CLEAR_ON_RESET != 0));

endmodule

// File: tb/tb_param_sync_dp_ram.sv
// Bench for param_sync_dp_ram: four configurations driven by one shared stimulus.
// Reads push expected words into per-instance queues; a negedge monitor checks them.
module tb_param_sync_dp_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        re;
    logic [2:0]  raddr;

    logic [7:0]  d0, d3;
    logic [15:0] d1, d2;
    logic        v0, v1, v2, v3;
    logic        b0, b1, b2, b3;

    logic [15:0] dout_a [4];
    logic        val_a  [4];
    logic        busy_a [4];

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t expq [4][$];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // u0: defaults, u1: 16-bit read-first, u2: 16-bit write-first, u3: 8-bit out reg
    param_sync_dp_ram u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din[7:0]),
        .be(be[0:0]), .re(re), .raddr(raddr), .dout(d0), .dout_valid(v0),
        .busy(b0));
    param_sync_dp_ram #(.DATA_WIDTH(16), .RD_MODE(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din),
        .be(be), .re(re), .raddr(raddr), .dout(d1), .dout_valid(v1),
        .busy(b1));
    param_sync_dp_ram #(.DATA_WIDTH(16), .RD_MODE(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din),
        .be(be), .re(re), .raddr(raddr), .dout(d2), .dout_valid(v2),
        .busy(b2));
    param_sync_dp_ram #(.OUT_REG(1)) u3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din[7:0]),
        .be(be[0:0]), .re(re), .raddr(raddr), .dout(d3), .dout_valid(v3),
        .busy(b3));

    always_comb begin
        dout_a[0] = {8'h00, d0};
        dout_a[1] = d1;
        dout_a[2] = d2;
        dout_a[3] = {8'h00, d3};
        val_a[0]  = v0;
        val_a[1]  = v1;
        val_a[2]  = v2;
        val_a[3]  = v3;
        busy_a[0] = b0;
        busy_a[1] = b1;
        busy_a[2] = b2;
        busy_a[3] = b3;
    end

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (val_a[k]) begin
                tests++;
                if (expq[k].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid dut%0d cyc=%0d dout=%h",
                             k, cyc_cnt, dout_a[k]);
                end else begin
                    e = expq[k].pop_front();
                    if (dout_a[k] !== e.data || cyc_cnt != e.due) begin
                        fails++;
                        $display("FAIL read dut%0d got %h at cyc %0d, want %h at cyc %0d",
                                 k, dout_a[k], cyc_cnt, e.data, e.due);
                    end
                end
            end else if (expq[k].size() > 0 && expq[k][0].due <= cyc_cnt) begin
                tests++;
                fails++;
                e = expq[k].pop_front();
                $display("FAIL missing_valid dut%0d cyc=%0d want %h",
                         k, cyc_cnt, e.data);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] v);
        exp_t e;
        e.due  = cyc_cnt + 1 + ((k == 3) ? 1 : 0);
        e.data = v;
        expq[k].push_back(e);
    endtask

    // One clock of stimulus; e8 covers u0/u3, e1/e2 the 16-bit instances.
    task automatic issue(input logic w, input logic [2:0] wa,
                         input logic [15:0] d, input logic [1:0] b,
                         input logic r, input logic [2:0] ra,
                         input logic [15:0] e8, input logic [15:0] e1,
                         input logic [15:0] e2, input bit no3 = 0);
        we    = w;
        waddr = wa;
        din   = d;
        be    = b;
        re    = r;
        raddr = ra;
        if (r) begin
            push(0, e8);
            push(1, e1);
            push(2, e2);
            if (!no3) push(3, e8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy_a[0] && n < 40);
        chk(name, 16'(n), 16'd8);
        for (int k = 0; k < 4; k++) chk("busy_low", {15'b0, busy_a[k]}, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        we = 0; waddr = 0; din = 0; be = 0; re = 0; raddr = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", {15'b0, busy_a[k]}, 16'h1);
            chk("rst_dout", dout_a[k], 16'h0);
            chk("rst_valid", {15'b0, val_a[k]}, 16'h0);
        end
        rst = 1'b0;
        wait_clear("clear_len");

        issue(0, 0, 0, 0, 1, 5, 16'h00, 16'h0000, 16'h0000);
        issue(1, 0, 16'h00AA, 2'b01, 0, 0, 0, 0, 0);
        issue(1, 1, 16'h00BB, 2'b01, 0, 0, 0, 0, 0);
        issue(1, 2, 16'h00CC, 2'b01, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 0, 16'hAA, 16'h00AA, 16'h00AA);
        issue(0, 0, 0, 0, 1, 1, 16'hBB, 16'h00BB, 16'h00BB);
        issue(0, 0, 0, 0, 1, 2, 16'hCC, 16'h00CC, 16'h00CC);
        idle(2);

        issue(1, 3, 16'h1234, 2'b11, 0, 0, 0, 0, 0);
        issue(1, 3, 16'hABCD, 2'b01, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 3, 16'hCD, 16'h12CD, 16'h12CD);

        issue(1, 4, 16'h1111, 2'b11, 0, 0, 0, 0, 0);
        issue(1, 4, 16'h2222, 2'b10, 1, 4, 16'h11, 16'h1111, 16'h2211);
        issue(0, 0, 0, 0, 1, 4, 16'h11, 16'h2211, 16'h2211);
        idle(2);

        issue(0, 0, 0, 0, 1, 0, 16'hAA, 16'h00AA, 16'h00AA);
        issue(0, 0, 0, 0, 1, 1, 16'hBB, 16'h00BB, 16'h00BB);
        idle(1);
        issue(0, 0, 0, 0, 1, 2, 16'hCC, 16'h00CC, 16'h00CC);

        issue(1, 7, 16'h7777, 2'b11, 1, 1, 16'hBB, 16'h00BB, 16'h00BB);
        issue(0, 0, 0, 0, 1, 7, 16'h77, 16'h7777, 16'h7777);
        issue(1, 0, 16'hFFFF, 2'b00, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 0, 16'hAA, 16'h00AA, 16'h00AA);
        idle(3);
        chk("hold_u0", dout_a[0], 16'h00AA);
        chk("hold_u1", dout_a[1], 16'h00AA);
        chk("hold_valid", {15'b0, val_a[3]}, 16'h0);

        issue(0, 0, 0, 0, 1, 0, 16'hAA, 16'h00AA, 16'h00AA, 1);
        rst = 1'b1;
        issue(1, 0, 16'h9999, 2'b11, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_dout", dout_a[k], 16'h0);
            chk("midrst_valid", {15'b0, val_a[k]}, 16'h0);
        end
        rst = 1'b0;
        idle(3);
        chk("clear_busy_mid", {15'b0, busy_a[0]}, 16'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wait_clear("clear_restart_len");

        issue(0, 0, 0, 0, 1, 0, 16'h00, 16'h0000, 16'h0000);
        idle(4);
        for (int k = 0; k < 4; k++) chk("queue_empty", 16'(expq[k].size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
